// File: rtl/snn_sched_pkg.sv
// Shared types for the membrane readout scheduler.
// Provides the scheduler state encoding and the timestep index width helper.
// Imported by membrane_readout_scheduler and mrs_out_stage.
package snn_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Width of a timestep index. A single timestep still needs one bit.
   function automatic int ts_width(input int num_timesteps);
      return (num_timesteps <= 2) ? 1 : $clog2(num_timesteps);
   endfunction

endpackage

// File: rtl/mrs_out_stage.sv
// Single-entry output register for one membrane vector and its timestep tag.
// Latency: 1 cycle from load to valid. Payload holds while valid && !ready.
// Ports: load/load_* capture a new entry, flush drops it, valid/ready/membranes/timestep/last form the stream.
module mrs_out_stage
   import snn_sched_pkg::*;
#(
   parameter int DATA_W = 384,
   parameter int TS_W   = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              flush,
   input  logic [DATA_W-1:0] load_membranes,
   input  logic [TS_W-1:0]   load_timestep,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] membranes,
   output logic [TS_W-1:0]   timestep,
   output logic              last
);

   // A load in the same cycle as an acceptance replaces the entry, which
   // keeps the stream at one vector per cycle under continuous ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid     <= 1'b0;
         membranes <= '0;
         timestep  <= '0;
         last      <= 1'b0;
      end else begin
         if (load) begin
            valid     <= 1'b1;
            membranes <= load_membranes;
            timestep  <= load_timestep;
            last      <= load_last;
         end else if (flush || (valid && ready)) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/membrane_readout_scheduler.sv
// Sequences one inference through the membrane buffer bank: fill, drain, done.
// Latency: first vector 1 cycle after drain entry, then up to 1 vector/cycle.
// Backpressure: out_ready low stalls the read pointer and holds the output register.
// Ports: start/abort control, lif_valid from the LIF layer, buf_* to/from the buffer
// bank, out_* valid/ready stream to the Q-value stage, busy/done/overrun_err status.
module membrane_readout_scheduler
   import snn_sched_pkg::*;
#(
   parameter int NUM_TIMESTEPS  = 30,
   parameter int NUM_NEURONS    = 16,
   parameter int MEMBRANE_WIDTH = 24,
   parameter int TS_W           = ts_width(NUM_TIMESTEPS)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                abort,
   input  logic                                lif_valid,
   output logic                                buf_clear,
   output logic                                buf_write_en,
   output logic [TS_W-1:0]                     buf_write_timestep,
   output logic [TS_W-1:0]                     buf_read_timestep,
   input  logic [NUM_NEURONS*MEMBRANE_WIDTH-1:0] buf_membranes,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [NUM_NEURONS*MEMBRANE_WIDTH-1:0] out_membranes,
   output logic [TS_W-1:0]                     out_timestep,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done,
   output logic                                overrun_err
);

   localparam int              DATA_W  = NUM_NEURONS * MEMBRANE_WIDTH;
   localparam logic [TS_W-1:0] LAST_TS = TS_W'(NUM_TIMESTEPS - 1);

   state_t          state;
   logic [TS_W-1:0] wr_ts;
   logic [TS_W-1:0] rd_ts;
   logic            issued_all;

   logic abort_hit;
   logic issue;
   logic last_accept;

   // Abort only matters once an inference is under way, and it outranks
   // every handshake in the same cycle.
   assign abort_hit   = abort && (state != ST_IDLE);
   assign issue       = (state == ST_DRAIN) && !abort && !issued_all
                        && (!out_valid || out_ready);
   assign last_accept = (state == ST_DRAIN) && !abort && out_valid && out_ready && out_last;

   // Clear is gated by reset so that a held start cannot reach the buffers
   // while the block is being reset.
   assign buf_clear          = !reset && (((state == ST_IDLE) && start) || abort_hit);
   assign buf_write_en       = (state == ST_FILL) && lif_valid && !abort;
   assign buf_write_timestep = wr_ts;
   assign buf_read_timestep  = rd_ts;

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         wr_ts       <= '0;
         rd_ts       <= '0;
         issued_all  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  wr_ts       <= '0;
                  overrun_err <= 1'b0;
                  state       <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (lif_valid) begin
                  // The final write lands on the same edge that enters DRAIN;
                  // the pointer parks at the last slot instead of wrapping.
                  if (wr_ts == LAST_TS) begin
                     rd_ts      <= '0;
                     issued_all <= 1'b0;
                     state      <= ST_DRAIN;
                  end else begin
                     wr_ts <= wr_ts + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else begin
                  if (issue) begin
                     if (rd_ts == LAST_TS) begin
                        issued_all <= 1'b1;
                     end else begin
                        rd_ts <= rd_ts + 1'b1;
                     end
                  end
                  if (last_accept) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         // A LIF vector arriving outside FILL has nowhere to go. Placed after
         // the start clear so a same-cycle overrun is still recorded.
         if (lif_valid && (state != ST_FILL)) begin
            overrun_err <= 1'b1;
         end
      end
   end

   mrs_out_stage #(
      .DATA_W (DATA_W),
      .TS_W   (TS_W)
   ) u_out_stage (
      .clk            (clk),
      .reset          (reset),
      .load           (issue),
      .flush          (abort_hit),
      .load_membranes (buf_membranes),
      .load_timestep  (rd_ts),
      .load_last      (rd_ts == LAST_TS),
      .ready          (out_ready),
      .valid          (out_valid),
      .membranes      (out_membranes),
      .timestep       (out_timestep),
      .last           (out_last)
   );

endmodule

// File: tb/tb_membrane_readout_scheduler.sv
module tb_membrane_readout_scheduler;

   localparam int NT = 4;
   localparam int NN = 2;
   localparam int MW = 24;
   localparam int TW = 2;
   localparam int DW = NN * MW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic          lif_valid;
   logic          buf_clear;
   logic          buf_write_en;
   logic [TW-1:0] buf_write_timestep;
   logic [TW-1:0] buf_read_timestep;
   logic [DW-1:0] buf_membranes;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_membranes;
   logic [TW-1:0] out_timestep;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          overrun_err;

   int checks   = 0;
   int failures = 0;
   int acc_cnt  = 0;

   typedef struct packed {
      logic [TW-1:0] ts;
      logic [DW-1:0] dat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Buffer bank model: neuron 1 = ts*16+1, neuron 0 = -(ts+1).
   function automatic logic [DW-1:0] model(input int ts);
      logic [MW-1:0] n0;
      logic [MW-1:0] n1;
      n0 = MW'(-(ts + 1));
      n1 = MW'(ts * 16 + 1);
      return {n1, n0};
   endfunction

   assign buf_membranes = model(int'(buf_read_timestep));

   membrane_readout_scheduler #(
      .NUM_TIMESTEPS  (NT),
      .NUM_NEURONS    (NN),
      .MEMBRANE_WIDTH (MW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .abort              (abort),
      .lif_valid          (lif_valid),
      .buf_clear          (buf_clear),
      .buf_write_en       (buf_write_en),
      .buf_write_timestep (buf_write_timestep),
      .buf_read_timestep  (buf_read_timestep),
      .buf_membranes      (buf_membranes),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_membranes      (out_membranes),
      .out_timestep       (out_timestep),
      .out_last           (out_last),
      .busy               (busy),
      .done               (done),
      .overrun_err        (overrun_err)
   );

   // Output monitor: inputs change just after posedge, so at negedge the
   // handshake that the next posedge will accept is visible and stable.
   logic          held = 1'b0;
   logic [DW-1:0] prev_dat;
   logic [TW-1:0] prev_ts;

   always @(negedge clk) begin
      exp_t e;
      if (reset || !out_valid) begin
         held = 1'b0;
      end else begin
         if (held) begin
            checks++;
            if (out_membranes !== prev_dat || out_timestep !== prev_ts) begin
               failures++;
               $display("FAIL hold_stable ts=%0d/%0d dat=%h/%h", out_timestep, prev_ts, out_membranes, prev_dat);
            end
         end
         if (out_ready) begin
            held = 1'b0;
            acc_cnt++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output ts=%0d with empty scoreboard", out_timestep);
            end else begin
               e = sb.pop_front();
               if (out_timestep !== e.ts || out_membranes !== e.dat || out_last !== (e.ts == TW'(NT - 1))) begin
                  failures++;
                  $display("FAIL sb_vector got ts=%0d dat=%h last=%b want ts=%0d dat=%h", out_timestep, out_membranes, out_last, e.ts, e.dat);
               end
            end
         end else begin
            held     = 1'b1;
            prev_dat = out_membranes;
            prev_ts  = out_timestep;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Drives NT lif_valid pulses separated by gap idle cycles, asserting start
   // alongside pulse start_at (use -1 for none). Called in FILL.
   task automatic fill(input int gap, input int start_at);
      exp_t e;
      for (int ts = 0; ts < NT; ts++) begin
         lif_valid = 1'b1;
         start     = (ts == start_at);
         e.ts      = TW'(ts);
         e.dat     = model(ts);
         sb.push_back(e);
         #1;
         checks++;
         if (buf_write_en !== 1'b1 || buf_write_timestep !== TW'(ts)) begin
            failures++;
            $display("FAIL fill_write en=%b wts=%0d want en=1 wts=%0d", buf_write_en, buf_write_timestep, ts);
         end
         checks++;
         if (buf_clear !== 1'b0) begin
            failures++;
            $display("FAIL fill_no_clear buf_clear=%b want 0", buf_clear);
         end
         tick();
         lif_valid = 1'b0;
         start     = 1'b0;
         if (ts < NT - 1) repeat (gap) tick();
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      checks++;
      if (busy !== 0 || out_valid !== 0 || out_membranes !== '0 || out_timestep !== '0 || out_last !== 0) begin
         failures++;
         $display("FAIL reset_out busy=%b vld=%b dat=%h ts=%0d last=%b want all 0", busy, out_valid, out_membranes, out_timestep, out_last);
      end
      checks++;
      if (done !== 0 || overrun_err !== 0 || buf_clear !== 0 || buf_write_en !== 0
          || buf_write_timestep !== '0 || buf_read_timestep !== '0) begin
         failures++;
         $display("FAIL reset_buf done=%b err=%b clr=%b we=%b wts=%0d rts=%0d want all 0", done, overrun_err, buf_clear, buf_write_en, buf_write_timestep, buf_read_timestep);
      end
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_nominal();
      bit seen;
      int base;
      base  = acc_cnt;
      start = 1'b1;
      #1;
      checks++;
      if (buf_clear !== 1'b1) begin
         failures++;
         $display("FAIL nom_clear buf_clear=%b want 1", buf_clear);
      end
      tick();
      start = 1'b0;
      fill(0, -1);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL nom_drain_entry vld=%b busy=%b want vld=0 busy=1", out_valid, busy);
      end
      for (int k = 0; k < NT; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_timestep !== TW'(k) || out_membranes !== model(k) || out_last !== (k == NT - 1)) begin
            failures++;
            $display("FAIL nom_stream vld=%b ts=%0d dat=%h last=%b want ts=%0d dat=%h", out_valid, out_timestep, out_membranes, out_last, k, model(k));
         end
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL nom_done done=%b busy=%b vld=%b want 1 1 0", done, busy, out_valid);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || acc_cnt != base + NT) begin
         failures++;
         $display("FAIL nom_idle done=%b busy=%b acc=%0d want 0 0 %0d", done, busy, acc_cnt - base, NT);
      end
      seen = 1'b0;
   endtask

   task automatic test_backpressure();
      bit            stalled;
      logic [DW-1:0] hold_dat;
      int            base;
      base    = acc_cnt;
      stalled = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      fill(2, -1);
      for (int i = 0; i < 40 && done !== 1'b1; i++) begin
         if (out_valid === 1'b1 && out_timestep === 2'd1 && !stalled) begin
            stalled   = 1'b1;
            out_ready = 1'b0;
            hold_dat  = out_membranes;
            checks++;
            if (hold_dat !== model(1)) begin
               failures++;
               $display("FAIL bp_payload dat=%h want %h", hold_dat, model(1));
            end
            repeat (3) begin
               tick();
               checks++;
               if (out_valid !== 1'b1 || out_timestep !== 2'd1 || out_membranes !== hold_dat) begin
                  failures++;
                  $display("FAIL bp_stall vld=%b ts=%0d dat=%h want 1 1 %h", out_valid, out_timestep, out_membranes, hold_dat);
               end
            end
            out_ready = 1'b1;
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || !stalled || acc_cnt != base + NT || sb.size() != 0) begin
         failures++;
         $display("FAIL bp_complete done=%b stalled=%b acc=%0d left=%0d want 1 1 %0d 0", done, stalled, acc_cnt - base, sb.size(), NT);
      end
      tick();
   endtask

   task automatic test_overrun();
      bit seen;
      int base;
      lif_valid = 1'b1;
      #1;
      checks++;
      if (buf_write_en !== 1'b0) begin
         failures++;
         $display("FAIL ovr_idle_write we=%b want 0", buf_write_en);
      end
      tick();
      lif_valid = 1'b0;
      checks++;
      if (overrun_err !== 1'b1) begin
         failures++;
         $display("FAIL ovr_idle_flag err=%b want 1", overrun_err);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (overrun_err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL ovr_start_clear err=%b busy=%b want 0 1", overrun_err, busy);
      end
      base = acc_cnt;
      fill(0, -1);
      lif_valid = 1'b1;
      #1;
      checks++;
      if (buf_write_en !== 1'b0) begin
         failures++;
         $display("FAIL ovr_drain_write we=%b want 0", buf_write_en);
      end
      tick();
      lif_valid = 1'b0;
      wait_done(seen);
      checks++;
      if (!seen || overrun_err !== 1'b1 || acc_cnt != base + NT) begin
         failures++;
         $display("FAIL ovr_drain seen=%b err=%b acc=%0d want 1 1 %0d", seen, overrun_err, acc_cnt - base, NT);
      end
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (overrun_err !== 1'b0) begin
         failures++;
         $display("FAIL ovr_next_start err=%b want 0", overrun_err);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ovr_abort_fill busy=%b want 0", busy);
      end
   endtask

   task automatic test_abort();
      bit seen;
      int base;
      base  = acc_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      fill(0, -1);
      for (int i = 0; i < 20 && acc_cnt < base + 2; i++) tick();
      abort     = 1'b1;
      out_ready = 1'b0;
      #1;
      checks++;
      if (buf_clear !== 1'b1 || acc_cnt != base + 2) begin
         failures++;
         $display("FAIL abort_clear clr=%b acc=%0d want 1 2", buf_clear, acc_cnt - base);
      end
      tick();
      abort = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle vld=%b busy=%b want 0 0", out_valid, busy);
      end
      sb.delete();
      out_ready = 1'b1;
      tick();
      base  = acc_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      fill(0, -1);
      wait_done(seen);
      checks++;
      if (!seen || acc_cnt != base + NT || sb.size() != 0) begin
         failures++;
         $display("FAIL abort_rerun seen=%b acc=%0d left=%0d want 1 %0d 0", seen, acc_cnt - base, sb.size(), NT);
      end
      tick();
   endtask

   task automatic test_async_reset();
      bit seen;
      int base;
      start = 1'b1;
      tick();
      start     = 1'b0;
      lif_valid = 1'b1;
      tick();
      tick();
      checks++;
      if (buf_write_timestep !== 2'd2) begin
         failures++;
         $display("FAIL rst_pre wts=%0d want 2", buf_write_timestep);
      end
      #2;
      reset = 1'b1;
      start = 1'b1;
      #1;
      checks++;
      if (busy !== 0 || buf_write_en !== 0 || buf_write_timestep !== '0 || buf_clear !== 0 || out_valid !== 0 || done !== 0) begin
         failures++;
         $display("FAIL rst_async busy=%b we=%b wts=%0d clr=%b vld=%b done=%b want all 0", busy, buf_write_en, buf_write_timestep, buf_clear, out_valid, done);
      end
      lif_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_start_ignored busy=%b want 0", busy);
      end
      reset = 1'b0;
      start = 1'b0;
      tick();
      base  = acc_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      fill(0, -1);
      wait_done(seen);
      checks++;
      if (!seen || acc_cnt != base + NT) begin
         failures++;
         $display("FAIL rst_rerun seen=%b acc=%0d want 1 %0d", seen, acc_cnt - base, NT);
      end
      tick();
   endtask

   task automatic test_start_ignored();
      bit seen;
      int base;
      base  = acc_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      fill(0, 1);
      tick();
      start = 1'b1;
      #1;
      checks++;
      if (buf_clear !== 1'b0 || out_timestep !== 2'd0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL start_drain clr=%b ts=%0d vld=%b want 0 0 1", buf_clear, out_timestep, out_valid);
      end
      tick();
      start = 1'b0;
      checks++;
      if (out_timestep !== 2'd1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL start_drain_seq ts=%0d vld=%b want 1 1", out_timestep, out_valid);
      end
      wait_done(seen);
      checks++;
      if (!seen || acc_cnt != base + NT) begin
         failures++;
         $display("FAIL start_complete seen=%b acc=%0d want 1 %0d", seen, acc_cnt - base, NT);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_idle busy=%b want 0", busy);
      end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      lif_valid = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_nominal();
      test_backpressure();
      test_overrun();
      test_abort();
      test_async_reset();
      test_start_ignored();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover entries=%0d want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/membrane_readout_scheduler.md
Name: membrane_readout_scheduler

Overview:
Sequences one inference through the bank of per-neuron membrane buffers that sit behind hidden layer 2.
- Fill phase: drives the shared write timestep and write enable while the LIF layer produces one membrane vector per timestep.
- Drain phase: steps the shared read timestep and streams registered membrane vectors, one per timestep, to the Q-value stage over a valid/ready handshake.
- End of inference: signals done and clears the buffers at the start of the next inference.

Parameters:
NUM_TIMESTEPS, 30, timesteps per inference (must be >= 2); TS_W = $clog2(NUM_TIMESTEPS)
NUM_NEURONS, 16, number of buffered neurons (buffers in the bank)
MEMBRANE_WIDTH, 24, signed membrane width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a new inference; honoured only in IDLE
abort  in  1  synchronous abandon; forces return to IDLE
lif_valid  in  1  LIF layer presents this timestep's membranes to the buffers
buf_clear  out  1  clear to all buffers
buf_write_en  out  1  write enable to all buffers
buf_write_timestep  out  TS_W  write slot to all buffers
buf_read_timestep  out  TS_W  read slot to all buffers
buf_membranes  in  NUM_NEURONS*MEMBRANE_WIDTH  concatenated combinational buffer outputs; neuron 0 in LSBs
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts
out_membranes  out  NUM_NEURONS*MEMBRANE_WIDTH  registered membrane vector
out_timestep  out  TS_W  timestep of out_membranes
out_last  out  1  out_timestep == NUM_TIMESTEPS-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the final vector is accepted
overrun_err  out  1  sticky error flag

Behaviour:
- Reset (async) values:
  - state=IDLE.
  - wr_ts=0, rd_ts=0.
  - out_valid=0, out_membranes=0, out_timestep=0, out_last=0.
  - done=0, overrun_err=0.
  - buf_* outputs all 0.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - buf_clear = start, combinational, same cycle.
  - On start: wr_ts<=0, overrun_err<=0, next state FILL.
- FILL:
  - buf_write_en = lif_valid, combinational.
  - buf_write_timestep = wr_ts.
  - On lif_valid: wr_ts++.
  - When lif_valid with wr_ts==NUM_TIMESTEPS-1: rd_ts<=0, next state DRAIN.
  - The last write lands on the same edge as the transition.
- DRAIN, issue rule:
  - buf_read_timestep = rd_ts.
  - issue = !issued_all && (!out_valid || out_ready).
  - On issue: out_membranes<=buf_membranes, out_timestep<=rd_ts, out_last<=(rd_ts==NUM_TIMESTEPS-1), out_valid<=1, rd_ts++.
  - Issuing at rd_ts==NUM_TIMESTEPS-1 sets issued_all.
- DRAIN, output stage:
  - out_valid && out_ready && !issue -> out_valid<=0.
  - Payload is held stable while out_valid && !out_ready.
  - With continuous out_ready, throughput is 1 vector/cycle.
  - First out_valid appears 1 cycle after DRAIN entry.
  - Acceptance of the out_last vector -> out_valid<=0, next state DONE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- rd_ts and wr_ts never wrap: they stop at NUM_TIMESTEPS-1, and a transition always occurs there.
- lif_valid in any state other than FILL:
  - Sets overrun_err; no buffer write occurs.
  - overrun_err stays set until the next accepted start.
- start outside IDLE: ignored, no effect.
- abort, any non-IDLE state:
  - Next state IDLE; out_valid<=0.
  - buf_clear=1 combinationally in that cycle.
  - abort in IDLE has no effect.
- abort has priority over start, lif_valid and out_ready handshakes in the same cycle.
- Reset mid-inference: everything returns to reset values immediately. Buffer contents are stale, and the next start clears them.

Decomposition:
- Package snn_sched_pkg: state enum (IDLE, FILL, DRAIN, DONE), timestep width function.
- Sub-module mrs_out_stage: single-entry valid/ready output register holding membranes, timestep and last.
- The FSM and counters stay in the top module.

Test Plan:
- Parameters NUM_TIMESTEPS=4, NUM_NEURONS=2, MEMBRANE_WIDTH=24; buffer model returns {ts*16+1, -(ts+1)}.
1. Nominal: start, then 4 consecutive lif_valid, out_ready held 1.
   - Required: buf_clear in the start cycle; buf_write_timestep 0..3; out_timestep 0,1,2,3 on consecutive cycles with correct payload; out_last only on ts 3.
   - done pulses 1 cycle after the ts-3 acceptance; busy drops with it.
2. Backpressure: out_ready low for 3 cycles on ts 1, with gaps of 2 between lif_valid pulses.
   - Required: ts-1 payload held stable; no vector dropped or duplicated; order 0..3.
3. Overrun: lif_valid in IDLE and in DRAIN.
   - Required: overrun_err=1, no buf_write_en, drain sequence unaffected; next start clears overrun_err.
4. Abort during DRAIN after ts 1 is accepted.
   - Required: out_valid=0 next cycle; buf_clear=1 in the abort cycle; state IDLE; a following start runs a full clean inference.
5. Async reset asserted mid-FILL at wr_ts=2.
   - Required: all outputs zero immediately; start ignored while in reset; a fresh start writes from ts 0.
6. start asserted during FILL and DRAIN.
   - Required: ignored; wr_ts and rd_ts sequences unchanged.
